bus_rx_endpoint: RTL and testbench
==================================

Name: bus_rx_endpoint

Overview:
Synthesizable receive endpoint for one device port of the bs_gnrtr_n_rbtr bus. It is the counterpart of the transmit-side driver. It captures words the bus delivers with push/D_push and filters them by destination ID. Accepted payloads are buffered in a first-word-fall-through FIFO and offered to the local consumer with valid/ready. Status counters cover accepted, misaddressed and overflow-dropped packets.

Parameters:
pckg_sz, 16, bus word width in bits; [pckg_sz-1 -: 8] is the destination ID and the rest is payload.
depth, 8, receive FIFO entries; must be a power of 2 and at least 2.
dev_id, 0, this endpoint's 8-bit ID.
bcst_id, 8'hFF, broadcast ID, accepted by every endpoint.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
push  in  1  bus strobe: D_push is valid this cycle.
D_push  in  pckg_sz  word delivered by the bus.
out_valid  out  1  head entry is available.
out_ready  in  1  consumer accepts the head entry.
out_data  out  pckg_sz-8  payload of the head entry.
out_bcst  out  1  head entry arrived with bcst_id.
count  out  $clog2(depth+1)  FIFO occupancy.
full  out  1  count == depth.
overflow  out  1  sticky flag: a matching packet was dropped because the FIFO was full.
rx_cnt  out  16  accepted packets, saturating.
misaddr_cnt  out  16  non-matching packets seen, saturating.
drop_cnt  out  16  matching packets dropped while full, saturating.
clr_stats  in  1  synchronous clear of the counters and of overflow.

Behaviour:
- Reset (asynchronous, active-high): pointers=0, count=0, out_valid=0, full=0, overflow=0, all counters=0, out_data=0, out_bcst=0. FIFO storage is not reset.
- Match rule: id = D_push[pckg_sz-1 -: 8]. A packet matches when push=1 and (id==dev_id or id==bcst_id). Sampled on the clk rising edge.
- Accept: match and (not full, or a pop occurs this cycle). Write payload and the bcst bit at wr_ptr, then wr_ptr+1 modulo depth, and rx_cnt+1.
- Misaddressed: push=1 and no match. Nothing is written; misaddr_cnt+1.
- Drop: match and full and no pop this cycle. Nothing is written; drop_cnt+1, overflow<=1.
- Pop: out_valid and out_ready. Then rd_ptr+1 modulo depth.
- count update: +1 on accept only, -1 on pop only, unchanged when both occur.
- FWFT output: out_valid = (count!=0). out_data and out_bcst show the head entry combinationally from storage.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N, i.e. in cycle N+1.
- Pop when empty is ignored, since out_valid=0.
- Simultaneous push and pop when empty: the write is accepted and the pop is ignored.
- Simultaneous push and pop when full: both are performed; count stays at depth and no drop occurs.
- Pointers wrap at depth without a gap, so depth consecutive accepts fill every entry.
- Counters: 16-bit and saturating at 16'hFFFF; no wrap.
- clr_stats=1: clears rx_cnt, misaddr_cnt, drop_cnt and overflow on the next edge. It overrides any increment or set in the same cycle. FIFO contents and count are unaffected.
- Reset mid-operation: the FIFO empties immediately (asynchronous). out_valid falls in the same cycle, and entries held before reset are lost.
- Control FSM, 2 states:
  - IDLE: count==0.
  - HOLD: count>0.
  - IDLE->HOLD on accept. HOLD->IDLE on pop with count==1 and no accept.
  - out_valid is the HOLD decode and must equal (count!=0) at all times; the bench asserts this.

Decomposition:
- Package bus_rx_pkg holds:
  - ID_W=8 and BCST_ID_DEFAULT=8'hFF.
  - STAT_W=16.
  - A typedef for the entry struct {logic bcst; logic [pckg_sz-ID_W-1:0] payload} via a parameterized width function.
  - A sat_inc function.
- Sub-module rx_fifo: generic synchronous FWFT FIFO with parameters width and depth. Ports: wr_en/wr_data, rd_en/rd_data, count, full, empty.
- bus_rx_endpoint contains only the match logic, counters, the FSM and the instance of rx_fifo.

Test Plan:
- Reset, then push D_push=16'h00AB with dev_id=0 → next cycle out_valid=1, out_data=8'hAB, out_bcst=0, count=1, rx_cnt=1.
- Push 16'h0312 with dev_id=0 → no write, out_valid stays 0, misaddr_cnt=1. Then push 16'hFF34 → out_data=8'h34, out_bcst=1.
- out_ready=0; push 10 matching words 8'h01..8'h0A → count=8, full=1, drop_cnt=2, overflow=1. Then drain → exactly 8'h01..8'h08 in order.
- Full FIFO, push 8'h55 with out_ready=1 in the same cycle → count stays 8, drop_cnt unchanged, 8'h55 emerges after the other 7 entries.
- Push 5 words with out_ready=1 held permanently, then 12 more words with out_ready=1 → pointer wrap observed, no loss, data order preserved, count returns to 0, FSM back in IDLE.
- Assert clr_stats in the same cycle as a misaddressed push → misaddr_cnt=0 and overflow=0 next cycle. Assert reset while count=3 → out_valid=0 immediately, count=0.

Source files
------------

// File: rtl/bus_rx_pkg.sv
// Shared constants, FSM states and helpers for the bus receive endpoint.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package bus_rx_pkg;

    localparam int ID_W                      = 8;
    localparam logic [ID_W-1:0] BCST_ID_DEFAULT = 8'hFF;
    localparam int STAT_W                    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rx_state_e;

    // Payload width left after the destination ID is stripped from a bus word.
    // The entry struct {bcst, payload} is declared per instance with this width.
    function automatic int pay_w(input int word_w);
        return word_w - ID_W;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Generic first-word-fall-through FIFO; head entry is visible combinationally.
// Latency: a write at edge N is readable in cycle N+1.
// Backpressure: writes when full are ignored unless a read frees a slot in the same cycle.
module rx_fifo #(
    parameter int width = 9,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [width-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [width-1:0]           rd_data,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth+1);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(depth));
    assign count = count_q;

    // Reads from an empty FIFO are dropped; a full write proceeds only alongside a read.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Empty FIFO drives zeros so the unreset storage never shows through.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers wrap naturally since depth is a power of two; count nets out simultaneous ops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd) count_d = count_q + 1'b1;
        if (do_rd && !do_wr) count_d = count_q - 1'b1;
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: filters pushed words by destination ID and queues payloads for the consumer.
// Latency: a matching word pushed at edge N is presented with out_valid=1 in cycle N+1.
// Backpressure: none toward the bus; matching words arriving while full (and no pop) are dropped and counted.
module bus_rx_endpoint
    import bus_rx_pkg::*;
#(
    parameter int              pckg_sz = 16,
    parameter int              depth   = 8,
    parameter logic [ID_W-1:0] dev_id  = 8'h00,
    parameter logic [ID_W-1:0] bcst_id = BCST_ID_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [pckg_sz-ID_W-1:0]    out_data,
    output logic                       out_bcst,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [STAT_W-1:0]          rx_cnt,
    output logic [STAT_W-1:0]          misaddr_cnt,
    output logic [STAT_W-1:0]          drop_cnt,
    input  logic                       clr_stats
);

    localparam int PAY_W = pay_w(pckg_sz);
    localparam int CNT_W = $clog2(depth+1);

    typedef struct packed {
        logic             bcst;
        logic [PAY_W-1:0] payload;
    } entry_t;

    logic [ID_W-1:0] id;
    logic            is_bcst, match, misaddr, pop, accept, drop;
    entry_t          wr_entry, rd_entry;
    logic            fifo_full;
    logic            unused_empty;
    rx_state_e       state_q, state_d;
    logic [STAT_W-1:0] rx_cnt_q, rx_cnt_d, mis_cnt_q, mis_cnt_d, drop_cnt_q, drop_cnt_d;
    logic            ovf_q, ovf_d;

    assign id      = D_push[pckg_sz-1 -: ID_W];
    assign is_bcst = (id == bcst_id);
    assign match   = push & ((id == dev_id) | is_bcst);
    assign misaddr = push & ~match;
    assign pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
    assign accept  = match & (~fifo_full | pop);
    assign drop    = match & fifo_full & ~pop;

    assign wr_entry.bcst    = is_bcst;
    assign wr_entry.payload = D_push[PAY_W-1:0];

    rx_fifo #(
        .width ($bits(entry_t)),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (unused_empty)
    );

    assign full        = fifo_full;
    assign out_data    = rd_entry.payload;
    assign out_bcst    = rd_entry.bcst;
    assign out_valid   = (state_q == ST_HOLD);
    assign overflow    = ovf_q;
    assign rx_cnt      = rx_cnt_q;
    assign misaddr_cnt = mis_cnt_q;
    assign drop_cnt    = drop_cnt_q;

    // Track empty/non-empty so out_valid comes straight from a register decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_HOLD;
            ST_HOLD: if (pop && !accept && count == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Statistics next state; clear wins over any increment or overflow set in the same cycle.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clr_stats) begin
            rx_cnt_d   = '0;
            mis_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (accept)  rx_cnt_d  = sat_inc(rx_cnt_q);
            if (misaddr) mis_cnt_d = sat_inc(mis_cnt_q);
            if (drop) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
                ovf_d      = 1'b1;
            end
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rx_cnt_q   <= '0;
            mis_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_cnt_q   <= rx_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed bench for bus_rx_endpoint with hand-computed expectations.
module tb_bus_rx_endpoint;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_bcst;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic [15:0] rx_cnt;
    logic [15:0] misaddr_cnt;
    logic [15:0] drop_cnt;
    logic        clr_stats;

    int vectors     = 0;
    int miscompares = 0;

    bus_rx_endpoint #(
        .pckg_sz (16),
        .depth   (8),
        .dev_id  (8'h00),
        .bcst_id (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .D_push      (D_push),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_bcst    (out_bcst),
        .count       (count),
        .full        (full),
        .overflow    (overflow),
        .rx_cnt      (rx_cnt),
        .misaddr_cnt (misaddr_cnt),
        .drop_cnt    (drop_cnt),
        .clr_stats   (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // out_valid must mirror occupancy at all times.
    always @(negedge clk) begin
        check("fsm_inv", 32'(out_valid), 32'(count != 4'd0));
    end

    initial begin
        reset = 1'b1; push = 1'b0; D_push = '0; out_ready = 1'b0; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_rx", 32'(rx_cnt), 0);
        check("rst_mis", 32'(misaddr_cnt), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_bcst", 32'(out_bcst), 0);
        reset = 1'b0;

        // Unicast accept, visible the cycle after the push edge.
        push = 1'b1; D_push = 16'h00AB;
        tick();
        push = 1'b0;
        check("uc_valid", 32'(out_valid), 1);
        check("uc_data", 32'(out_data), 32'hAB);
        check("uc_bcst", 32'(out_bcst), 0);
        check("uc_count", 32'(count), 1);
        check("uc_rx", 32'(rx_cnt), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("uc_drain_cnt", 32'(count), 0);
        check("uc_drain_data", 32'(out_data), 0);

        // Misaddressed word is not stored; broadcast is.
        push = 1'b1; D_push = 16'h0312;
        tick();
        check("mis_valid", 32'(out_valid), 0);
        check("mis_cnt", 32'(misaddr_cnt), 1);
        check("mis_rx", 32'(rx_cnt), 1);
        D_push = 16'hFF34;
        tick();
        push = 1'b0;
        check("bc_data", 32'(out_data), 32'h34);
        check("bc_bcst", 32'(out_bcst), 1);
        check("bc_rx", 32'(rx_cnt), 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bc_drain_cnt", 32'(count), 0);

        // Overfill with no consumer: 8 kept, 2 dropped.
        for (int i = 1; i <= 10; i++) begin
            push = 1'b1; D_push = 16'(i);
            tick();
        end
        push = 1'b0;
        check("ovf_count", 32'(count), 8);
        check("ovf_full", 32'(full), 1);
        check("ovf_drop", 32'(drop_cnt), 2);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_rx", 32'(rx_cnt), 10);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_empty", 32'(count), 0);

        // Push and pop together while full: no drop, count holds.
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; D_push = 16'h0011 + 16'(i);
            tick();
        end
        D_push = 16'h0055; out_ready = 1'b1;
        check("fp_head", 32'(out_data), 32'h11);
        tick();
        push = 1'b0; out_ready = 1'b0;
        check("fp_count", 32'(count), 8);
        check("fp_full", 32'(full), 1);
        check("fp_drop", 32'(drop_cnt), 2);
        check("fp_rx", 32'(rx_cnt), 19);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("fp_order", 32'(out_data), 32'h12 + 32'(i));
            tick();
        end
        check("fp_last", 32'(out_data), 32'h55);
        tick();
        check("fp_empty", 32'(count), 0);

        // Streaming with the consumer always ready: pointers wrap twice.
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; D_push = 16'h0021 + 16'(i);
            tick();
            check("st_data", 32'(out_data), 32'h21 + 32'(i));
            check("st_count", 32'(count), 1);
        end
        for (int i = 0; i < 12; i++) begin
            push = 1'b1; D_push = 16'h0030 + 16'(i);
            tick();
            check("wr_data", 32'(out_data), 32'h30 + 32'(i));
            check("wr_count", 32'(count), 1);
        end
        push = 1'b0;
        tick();
        out_ready = 1'b0;
        check("st_idle_cnt", 32'(count), 0);
        check("st_idle_valid", 32'(out_valid), 0);
        check("st_rx", 32'(rx_cnt), 36);
        check("st_ovf_sticky", 32'(overflow), 1);

        // Clear overrides the misaddress increment in the same cycle.
        push = 1'b1; D_push = 16'h0777; clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_mis", 32'(misaddr_cnt), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_rx", 32'(rx_cnt), 0);
        check("clr_drop", 32'(drop_cnt), 0);
        tick();
        push = 1'b0;
        check("clr_resume", 32'(misaddr_cnt), 1);

        // Asynchronous reset with entries held.
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = 16'h0041 + 16'(i);
            tick();
        end
        push = 1'b0;
        check("pre_rst_cnt", 32'(count), 3);
        check("pre_rst_data", 32'(out_data), 32'h41);
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_mis", 32'(misaddr_cnt), 0);
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 0);
        check("post_rst_count", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
